one_to_sixteen_deserializer: RTL and testbench
==============================================

// Module: one_to_sixteen_deserializer
// PURPOSE
//   Serial-to-parallel receive stage downstream of the 16-to-1 serializer; same clock domain.
//   Captures the LSB-first bit stream framed by active-low ss and assembles WIDTH-bit words.
//   Presents each word on data_output, held with data_valid until the consumer acks it.
// PARAMETERS
//   WIDTH    16   word length in bits; also the number of ss-low sampling edges per word
//   CNT_W    5    bit-counter width, = $clog2(WIDTH)+1
// PORTS
//   clock        in   1      single system clock, rising-edge
//   reset        in   1      synchronous, active-high reset
//   ss           in   1      frame select, active low; one bit is sampled per clock while low
//   data_input   in   1      serial data, LSB first
//   data_ack     in   1      consumer has taken data_output; sampled only while data_valid=1
//   data_output  out  WIDTH  last complete word, held stable while data_valid=1
//   data_valid   out  1      complete word pending
//   overrun      out  1      sticky: a word completed while the previous word was unacked
//   busy         out  1      1 in RECV or END
//   frame_error  out  1      sticky; present only with DESER_FRAME_CHECK_EN
// BEHAVIOUR
//   Reset: state=IDLE, count=0, shift register=0, data_output=0, data_valid=0, overrun=0,
//     frame_error=0. Reset mid-frame discards the partial word. Reset dominates all other inputs.
//   FSM states: IDLE=2'b00, RECV=2'b01, END=2'b10; 2'b11 is illegal and recovers to IDLE.
//   IDLE: on an edge with ss=0, sample bit 0, set count=1, go to RECV. Otherwise stay in IDLE.
//   RECV, ss=0: shift {data_input, sreg[WIDTH-1:1]}, count++.
//     On the WIDTH-th sample, go to END and load the word (bit k lands in data_output[k]).
//   Load rules, evaluated on the same edge:
//     data_valid=0, or data_valid=1 with data_ack=1: load data_output; data_valid=1.
//     data_valid=1 with data_ack=0: drop the new word, keep the old one, set overrun=1.
//   Latency: data_valid is visible after the WIDTH-th sampling edge, i.e. WIDTH edges after ss fell.
//   RECV, ss=1 before WIDTH bits: discard the partial word, count=0, go to IDLE.
//     With the macro, also set frame_error.
//   END: ignore data_input and wait for ss=1, then go to IDLE.
//     Bits clocked in while ss stays low past WIDTH are discarded.
//   Ack: data_valid=1 and data_ack=1 with no completing word -> data_valid=0 on the next edge.
//     data_ack while data_valid=0 has no effect.
//   overrun and frame_error clear only on reset.
// CONFIGURATION
//   DESER_FRAME_CHECK_EN defined:
//     frame_error port exists; set on a short frame (ss rises in RECV).
//     Frames longer than WIDTH (ss still low in END for more than one edge) also set it.
//   DESER_FRAME_CHECK_EN undefined:
//     no frame_error port; short or long frames are discarded or truncated silently.
// STRUCTURE
//   Shared package deser_pkg: state encodings IDLE/RECV/END, default WIDTH, CNT_W function.
//   Sub-module shift_register_sipo (WIDTH, enable, serial in, parallel out, sync reset).
//   The top level holds the FSM, bit counter and output register.
// TESTING
//   1. ss low for 16 clocks with serial stream of 16'hA5C3 (LSB first)
//      -> data_output=16'hA5C3, data_valid=1 after the 16th edge, busy=0 after ss rises.
//   2. Word pending, no ack, second full frame of 16'h1234
//      -> data_output stays 16'hA5C3, overrun=1.
//   3. data_ack asserted on the same edge that frame 16'h00FF completes
//      -> data_output=16'h00FF, data_valid stays 1, overrun=0.
//   4. ss rises after 7 bits
//      -> state IDLE, data_valid unchanged, frame_error=1 with the macro, port absent without.
//   5. reset pulsed at bit 9 of a frame, then a full frame of 16'hBEEF
//      -> all outputs 0 after reset, then data_output=16'hBEEF.
//   6. ss held low for 20 clocks with 16'h8001 followed by 4 extra bits
//      -> data_output=16'h8001, extra bits ignored; frame_error=1 only with the macro.

Source files
------------

// File: rtl/deser_pkg.sv
// Shared definitions for the serial-to-parallel receive stage.
//   state_t        : FSM state encoding (IDLE / RECV / END; 2'b11 is unused)
//   DEFAULT_WIDTH  : default word length in bits
//   cnt_w()        : bit-counter width for a given word length
// No ports (package).
package deser_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RECV = 2'b01,
        END  = 2'b10
    } state_t;

    localparam int DEFAULT_WIDTH = 16;

    // Counter must be able to hold the value WIDTH itself, hence the +1.
    function automatic int cnt_w(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/shift_register_sipo.sv
// Serial-in / parallel-out shift register, LSB-first.
// Each enabled edge shifts serial_in into the MSB and moves everything one
// place toward bit 0, so after WIDTH shifts the first bit sits in bit 0.
// Ports:
//   clock        in   1      rising-edge clock
//   reset        in   1      synchronous active-high reset (clears contents)
//   clear        in   1      synchronous clear, has priority over enable
//   enable       in   1      shift one bit in on this edge
//   serial_in    in   1      serial data bit
//   parallel_out out  WIDTH  current register contents
module shift_register_sipo #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic             serial_in,
    output logic [WIDTH-1:0] parallel_out
);

    logic [WIDTH-1:0] sreg_q;
    logic [WIDTH-1:0] sreg_d;

    always_comb begin
        sreg_d = sreg_q;
        if (clear) begin
            sreg_d = '0;
        end else if (enable) begin
            sreg_d = {serial_in, sreg_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sreg_q <= '0;
        end else begin
            sreg_q <= sreg_d;
        end
    end

    assign parallel_out = sreg_q;

endmodule

// File: rtl/one_to_sixteen_deserializer.sv
// Serial-to-parallel receive stage. Captures an LSB-first bit stream framed
// by active-low ss and presents each WIDTH-bit word on data_output, held
// together with data_valid until the consumer acknowledges it.
// Optional feature macro: DESER_FRAME_CHECK_EN (adds the sticky frame_error
// output flagging short and over-long frames).
// Ports:
//   clock        in   1      rising-edge system clock
//   reset        in   1      synchronous active-high reset
//   ss           in   1      frame select, active low; one bit sampled per edge while low
//   data_input   in   1      serial data, LSB first
//   data_ack     in   1      consumer took data_output (only meaningful while data_valid=1)
//   data_output  out  WIDTH  last accepted word
//   data_valid   out  1      a word is pending
//   overrun      out  1      sticky: word completed while previous one was unacked
//   busy         out  1      FSM in RECV or END
//   debug_state  out  2      raw FSM state
//   frame_error  out  1      sticky framing error (DESER_FRAME_CHECK_EN only)
//
// Handshake: data_output/data_valid form a valid/ack pair. A word is consumed
// on any edge where data_valid=1 and data_ack=1; a word completing on that
// same edge replaces it and data_valid stays high. A word completing while
// data_valid=1 and data_ack=0 is dropped and overrun is set.
module one_to_sixteen_deserializer
    import deser_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = cnt_w(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ss,
    input  logic             data_input,
    input  logic             data_ack,
    output logic [WIDTH-1:0] data_output,
    output logic             data_valid,
    output logic             overrun,
    output logic             busy,
`ifdef DESER_FRAME_CHECK_EN
    output logic             frame_error,
`endif
    output logic [1:0]       debug_state
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] data_output_q, data_output_d;
    logic             data_valid_q, data_valid_d;
    logic             overrun_q, overrun_d;
`ifdef DESER_FRAME_CHECK_EN
    logic             frame_error_q, frame_error_d;
`endif

    logic             shift_en;
    logic             shift_clr;
    logic             word_done;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] shift_word;
    logic             unused_sreg_lsb;

    shift_register_sipo #(
        .WIDTH(WIDTH)
    ) u_sipo (
        .clock       (clock),
        .reset       (reset),
        .clear       (shift_clr),
        .enable      (shift_en),
        .serial_in   (data_input),
        .parallel_out(sreg)
    );

    // The completed word includes the bit being sampled on this very edge,
    // so it is formed from the register contents plus the incoming bit.
    assign shift_word      = {data_input, sreg[WIDTH-1:1]};
    assign unused_sreg_lsb = sreg[0];

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        data_output_d = data_output_q;
        data_valid_d  = data_valid_q;
        overrun_d     = overrun_q;
`ifdef DESER_FRAME_CHECK_EN
        frame_error_d = frame_error_q;
`endif
        shift_en      = 1'b0;
        shift_clr     = 1'b0;
        word_done     = 1'b0;

        case (state_q)
            IDLE: begin
                if (!ss) begin
                    shift_en = 1'b1;
                    count_d  = CNT_W'(1);
                    state_d  = RECV;
                end
            end
            RECV: begin
                if (!ss) begin
                    shift_en = 1'b1;
                    if (count_q == CNT_W'(WIDTH - 1)) begin
                        word_done = 1'b1;
                        state_d   = END;
                        // In END the counter is reused to note that ss has
                        // already stayed low for one edge past the word.
                        count_d   = '0;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end else begin
                    // Short frame: throw away the partial word.
                    shift_clr = 1'b1;
                    count_d   = '0;
                    state_d   = IDLE;
`ifdef DESER_FRAME_CHECK_EN
                    frame_error_d = 1'b1;
`endif
                end
            end
            END: begin
                if (ss) begin
                    count_d = '0;
                    state_d = IDLE;
                end else begin
                    // One trailing low edge is tolerated; a second marks the
                    // frame as too long. Extra bits are never shifted in.
                    if (count_q != '0) begin
`ifdef DESER_FRAME_CHECK_EN
                        frame_error_d = 1'b1;
`endif
                    end else begin
                        count_d = CNT_W'(1);
                    end
                end
            end
            default: begin
                shift_clr = 1'b1;
                count_d   = '0;
                state_d   = IDLE;
            end
        endcase

        if (word_done) begin
            if (!data_valid_q || data_ack) begin
                data_output_d = shift_word;
                data_valid_d  = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (data_valid_q && data_ack) begin
            data_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            count_q       <= '0;
            data_output_q <= '0;
            data_valid_q  <= 1'b0;
            overrun_q     <= 1'b0;
`ifdef DESER_FRAME_CHECK_EN
            frame_error_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            data_output_q <= data_output_d;
            data_valid_q  <= data_valid_d;
            overrun_q     <= overrun_d;
`ifdef DESER_FRAME_CHECK_EN
            frame_error_q <= frame_error_d;
`endif
        end
    end

    assign data_output = data_output_q;
    assign data_valid  = data_valid_q;
    assign overrun     = overrun_q;
    assign busy        = (state_q == RECV) || (state_q == END);
    assign debug_state = state_q;
`ifdef DESER_FRAME_CHECK_EN
    assign frame_error = frame_error_q;
`endif

endmodule

// File: tb/tb_one_to_sixteen_deserializer.sv
// Self-checking bench for one_to_sixteen_deserializer: directed scenarios
// followed by randomized frames, every cycle compared against a frame-level
// reference model. Works with and without DESER_FRAME_CHECK_EN.
module tb_one_to_sixteen_deserializer;

    localparam int W = 16;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         ss = 1'b1;
    logic         data_input = 1'b0;
    logic         data_ack = 1'b0;
    logic [W-1:0] data_output;
    logic         data_valid;
    logic         overrun;
    logic         busy;
    logic [1:0]   debug_state;
`ifdef DESER_FRAME_CHECK_EN
    logic         frame_error;
`endif

    always #5 clock = ~clock;

    one_to_sixteen_deserializer dut (
        .clock      (clock),
        .reset      (reset),
        .ss         (ss),
        .data_input (data_input),
        .data_ack   (data_ack),
        .data_output(data_output),
        .data_valid (data_valid),
        .overrun    (overrun),
        .busy       (busy),
`ifdef DESER_FRAME_CHECK_EN
        .frame_error(frame_error),
`endif
        .debug_state(debug_state)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: bits of the frame in progress are collected in a
    // queue; the word is built arithmetically once W bits have arrived.
    bit           m_bits[$];
    bit           m_done;      // full word captured, waiting for ss to rise
    int           m_extra;     // low edges seen after the word completed
    logic [W-1:0] m_dout;
    bit           m_valid;
    bit           m_ovr;
    bit           m_ferr;

    task automatic model_step(input bit rst, input bit s, input bit d, input bit a);
        logic [W-1:0] word;
        bit           complete;
        complete = 1'b0;
        word     = '0;
        if (rst) begin
            m_bits.delete();
            m_done  = 1'b0;
            m_extra = 0;
            m_dout  = '0;
            m_valid = 1'b0;
            m_ovr   = 1'b0;
            m_ferr  = 1'b0;
            return;
        end
        if (!s) begin
            if (!m_done) begin
                m_bits.push_back(d);
                if (m_bits.size() == W) begin
                    for (int k = 0; k < W; k++) word = word + (W'(m_bits[k]) << k);
                    complete = 1'b1;
                    m_done   = 1'b1;
                    m_extra  = 0;
                    m_bits.delete();
                end
            end else begin
                m_extra++;
`ifdef DESER_FRAME_CHECK_EN
                if (m_extra > 1) m_ferr = 1'b1;
`endif
            end
        end else begin
`ifdef DESER_FRAME_CHECK_EN
            if (m_bits.size() > 0) m_ferr = 1'b1;
`endif
            m_bits.delete();
            m_done  = 1'b0;
            m_extra = 0;
        end
        if (complete) begin
            if (!m_valid || a) begin
                m_dout  = word;
                m_valid = 1'b1;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (m_valid && a) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic compare_all();
        logic [1:0] exp_state;
        exp_state = m_done ? 2'b10 : ((m_bits.size() > 0) ? 2'b01 : 2'b00);
        check("data_output", 32'(data_output), 32'(m_dout));
        check("data_valid", 32'(data_valid), 32'(m_valid));
        check("overrun", 32'(overrun), 32'(m_ovr));
        check("busy", 32'(busy), 32'(m_done || (m_bits.size() > 0)));
        check("state", 32'(debug_state), 32'(exp_state));
`ifdef DESER_FRAME_CHECK_EN
        check("frame_error", 32'(frame_error), 32'(m_ferr));
`endif
    endtask

    // One clock: drive inputs away from the rising edge, advance the model
    // with the same inputs the DUT samples, compare on the falling edge.
    task automatic cycle(input bit rst, input bit s, input bit d, input bit a);
        reset      = rst;
        ss         = s;
        data_input = d;
        data_ack   = a;
        @(posedge clock);
        model_step(rst, s, d, a);
        @(negedge clock);
        compare_all();
    endtask

    // nbits low edges carrying word LSB first (random bits past W), then ss high.
    task automatic send_frame(input logic [31:0] word, input int nbits, input bit ack_last);
        for (int i = 0; i < nbits; i++) begin
            cycle(1'b0, 1'b0, (i < W) ? word[i] : 1'($urandom_range(0, 1)),
                  ack_last && (i == W - 1));
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        @(negedge clock);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check("rst_dout", 32'(data_output), 32'h0);
        check("rst_valid", 32'(data_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);

        // 1: basic frame
        send_frame(32'hA5C3, W, 1'b0);
        check("s1_dout", 32'(data_output), 32'hA5C3);
        check("s1_valid", 32'(data_valid), 32'h1);
        check("s1_busy", 32'(busy), 32'h0);

        // 2: second frame while first unacked -> dropped, overrun
        send_frame(32'h1234, W, 1'b0);
        check("s2_dout", 32'(data_output), 32'hA5C3);
        check("s2_overrun", 32'(overrun), 32'h1);

        // 3: ack on the completing edge replaces the word
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        send_frame(32'hA5C3, W, 1'b0);
        send_frame(32'h00FF, W, 1'b1);
        check("s3_dout", 32'(data_output), 32'h00FF);
        check("s3_valid", 32'(data_valid), 32'h1);
        check("s3_overrun", 32'(overrun), 32'h0);

        // 4: short frame of 7 bits
        send_frame(32'h5A5A, 7, 1'b0);
        check("s4_state", 32'(debug_state), 32'h0);
        check("s4_valid", 32'(data_valid), 32'h1);
        check("s4_dout", 32'(data_output), 32'h00FF);
`ifdef DESER_FRAME_CHECK_EN
        check("s4_frame_error", 32'(frame_error), 32'h1);
`endif

        // 5: reset at bit 9, then a full frame
        for (int i = 0; i < 9; i++) cycle(1'b0, 1'b0, 1'((32'hBEEF >> i) & 1), 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        check("s5_rst_dout", 32'(data_output), 32'h0);
        check("s5_rst_valid", 32'(data_valid), 32'h0);
        check("s5_rst_overrun", 32'(overrun), 32'h0);
        check("s5_rst_busy", 32'(busy), 32'h0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        send_frame(32'hBEEF, W, 1'b0);
        check("s5_dout", 32'(data_output), 32'hBEEF);

        // 6: long frame, 4 extra bits ignored
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        send_frame(32'h8001, W + 4, 1'b0);
        check("s6_dout", 32'(data_output), 32'h8001);
        check("s6_valid", 32'(data_valid), 32'h1);
`ifdef DESER_FRAME_CHECK_EN
        check("s6_frame_error", 32'(frame_error), 32'h1);
`endif

        // ack while idle clears valid; ack with valid low is harmless
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        check("ack_clear", 32'(data_valid), 32'h0);
        cycle(1'b0, 1'b1, 1'b0, 1'b1);

        // randomized frames with random acks, lengths and occasional resets
        for (int f = 0; f < 60; f++) begin
            int nbits;
            int gap;
            logic [31:0] word;
            if ($urandom_range(0, 19) == 0) cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) cycle(1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 1)));
            nbits = ($urandom_range(0, 3) == 0) ? $urandom_range(1, W + 4) : W;
            word  = $urandom;
            for (int i = 0; i < nbits; i++) begin
                cycle(1'b0, 1'b0, (i < W) ? word[i] : 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 4) == 0));
            end
            cycle(1'b0, 1'b1, 1'b0, ($urandom_range(0, 2) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
